// File: rtl/viterbi_pkg.sv
// Types and constants shared by the convolutional encoder and the Viterbi ACS/traceback path.
package viterbi_pkg;

  localparam int K = 3;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  // Same encoding as the ACS self_state/addr ports and the data_recv symbols.
  typedef logic [K-2:0] trellis_state_t;
  typedef logic [1:0]   symbol_t;

  typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} enc_fsm_t;

endpackage

// File: rtl/conv_enc_core.sv
// One trellis step of the rate-1/2 encoder: (u, {s1,s0}) -> (code symbol, next state).
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic           u_i,
  input  trellis_state_t state_i,
  input  logic [K-1:0]   g0_i,
  input  logic [K-1:0]   g1_i,
  output symbol_t        sym_o,
  output trellis_state_t nextState_o
);

  logic [K-1:0] tapVec;

  assign tapVec      = {u_i, state_i};
  assign sym_o       = {^(tapVec & g0_i), ^(tapVec & g1_i)};
  assign nextState_o = {u_i, state_i[1]};

endmodule

// File: rtl/conv_encoder_tx.sv
// Frame-based rate-1/2 K=3 convolutional encoder with valid/ready on both sides
// and two zero tail bits that return the trellis to state 00.
module conv_encoder_tx
  import viterbi_pkg::*;
#(
  parameter int           FRAME_LEN = 16,
  parameter logic [K-1:0] G0        = G0_DEFAULT,
  parameter logic [K-1:0] G1        = G1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [1:0] sym_out,
  output logic [1:0] state_out,
  output logic       frame_last,
  output logic       busy,
  output logic       done
);

  localparam int            CW        = $clog2(FRAME_LEN + 2);
  localparam logic [CW-1:0] LAST_DATA = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] LAST_TAIL = CW'(FRAME_LEN + 1);

  enc_fsm_t       fsm_q, fsm_d;
  logic [CW-1:0]  count_q, count_d;
  trellis_state_t shift_q, shift_d;
  logic           symValid_q, symValid_d;
  symbol_t        sym_q, sym_d;
  trellis_state_t stateOut_q, stateOut_d;
  logic           last_q, last_d;
  logic           done_q, done_d;

  logic           canLoad;
  logic           bitAvail;
  logic           load;
  logic           uBit;
  symbol_t        coreSym;
  trellis_state_t coreNext;

  assign canLoad  = !symValid_q || sym_ready;
  assign bitAvail = ((fsm_q == DATA) && in_valid) || (fsm_q == TAIL);
  assign load     = canLoad && bitAvail;
  assign uBit     = (fsm_q == DATA) ? in_bit : 1'b0;

  conv_enc_core u_core (
    .u_i         (uBit),
    .state_i     (shift_q),
    .g0_i        (G0),
    .g1_i        (G1),
    .sym_o       (coreSym),
    .nextState_o (coreNext)
  );

  always_comb begin
    fsm_d      = fsm_q;
    count_d    = count_q;
    shift_d    = shift_q;
    symValid_d = symValid_q;
    sym_d      = sym_q;
    stateOut_d = stateOut_q;
    last_d     = last_q;
    done_d     = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d   = DATA;
          count_d = '0;
          shift_d = '0;
        end
      end
      DATA:  if (load && (count_q == LAST_DATA)) fsm_d = TAIL;
      TAIL:  if (load && (count_q == LAST_TAIL)) fsm_d = FLUSH;
      // done is held one cycle before IDLE so a start coinciding with it is ignored.
      FLUSH: begin
        if (done_q)                       fsm_d  = IDLE;
        else if (symValid_q && sym_ready) done_d = 1'b1;
      end
      default: fsm_d = IDLE;
    endcase

    if (load) begin
      symValid_d = 1'b1;
      sym_d      = coreSym;
      stateOut_d = shift_q;
      last_d     = (count_q == LAST_TAIL);
      shift_d    = coreNext;
      if (count_q != LAST_TAIL) count_d = count_q + CW'(1);
    end else if (sym_ready) begin
      symValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      count_q    <= '0;
      shift_q    <= '0;
      symValid_q <= 1'b0;
      sym_q      <= '0;
      stateOut_q <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      symValid_q <= symValid_d;
      sym_q      <= sym_d;
      stateOut_q <= stateOut_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign in_ready   = (fsm_q == DATA) && canLoad;
  assign sym_valid  = symValid_q;
  assign sym_out    = sym_q;
  assign state_out  = stateOut_q;
  assign frame_last = last_q;
  assign busy       = (fsm_q != IDLE);
  assign done       = done_q;

endmodule
